ws2812_tx_sequencer: RTL and testbench
======================================

WS2812_TX_SEQUENCER -- requirements
Module: ws2812_tx_sequencer

Interface
REQ-001 Parameter T0H, default 11, high time of a "0" bit in clk cycles (0.4 us at 27 MHz).
REQ-002 Parameter T1H, default 22, high time of a "1" bit in clk cycles (0.8 us).
REQ-003 Parameter TBIT, default 34, total period of one bit in clk cycles (1.25 us); TBIT > T1H > T0H >= 1.
REQ-004 Parameter TLATCH, default 1500, low time that latches the strip after the last bit, in clk cycles (55 us).
REQ-005 clk  in  1  single system clock; all logic is clocked on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to refresh the strip.
REQ-008 led_count  in  8  number of LEDs to send; sampled in the cycle where start is accepted.
REQ-009 pix_rd  out  1  one-cycle read strobe to the pixel RAM.
REQ-010 pix_addr  out  8  pixel index being read; valid while pix_rd=1.
REQ-011 pix_data  in  24  GRB word {G[7:0],R[7:0],B[7:0]}, valid exactly 1 cycle after pix_rd.
REQ-012 busy  out  1  high from start acceptance until the cycle done is pulsed.
REQ-013 done  out  1  one-cycle pulse when the frame, including the latch period, is complete.
REQ-014 ws2812_dout  out  1  serial line to the LED strip; registered output.

Function
REQ-015 States SHALL be IDLE, FETCH, WAIT_DATA, SEND, LATCH.
REQ-016 IDLE: start=1 with led_count>0 -> FETCH; set busy=1, pixel index=0, and latch led_count.
REQ-017 IDLE: start=1 with led_count=0 -> no pixel reads, line held low, done=1 next cycle, busy stays 0.
REQ-018 start while busy=1 SHALL be ignored; led_count changes after acceptance SHALL have no effect.
REQ-019 FETCH: pix_rd=1 and pix_addr=index for exactly one cycle -> WAIT_DATA.
REQ-020 WAIT_DATA: load pix_data into the 24-bit shift register and set the bit counter to 23 -> SEND; the first bit rises on the next cycle.
REQ-021 SEND: bits are sent MSB first (G7 first, B0 last); each bit lasts exactly TBIT cycles, with ws2812_dout=1 for the first T1H cycles (bit=1) or T0H cycles (bit=0), then 0 for the remainder.
REQ-022 Prefetch: in the first cycle of bit 23 of pixel i, if i+1 < led_count, issue pix_rd with pix_addr=i+1; capture pix_data into a holding register 1 cycle later.
REQ-023 At the end of bit 0 of pixel i, if more pixels remain, load the holding register into the shift register with no idle cycle; bit periods SHALL be contiguous across pixels.
REQ-024 At the end of bit 0 of the last pixel (index led_count-1) -> LATCH with ws2812_dout=0.
REQ-025 LATCH: hold ws2812_dout=0 for TLATCH cycles; in the last cycle, pulse done=1 and go to IDLE, with busy=0 from the following cycle.
REQ-026 A frame with N LEDs SHALL take exactly 2 + 24*N*TBIT + TLATCH cycles from the start cycle to the done cycle, inclusive of the 2-cycle fetch.
REQ-027 led_count=255 SHALL read addresses 0..254; the pixel index SHALL never wrap.
REQ-028 The phase counter and latch counter SHALL be wide enough for TBIT and TLATCH; no counter SHALL wrap during normal operation.
REQ-029 pix_rd SHALL never be asserted outside FETCH and the prefetch cycle, and at most once per pixel.

Reset
REQ-030 When reset=1, on the next edge: state=IDLE, ws2812_dout=0, busy=0, done=0, pix_rd=0, pix_addr=0, and all counters and data registers cleared.
REQ-031 Reset mid-frame SHALL abort immediately, with the line low from the next cycle; no done pulse for the aborted frame; a start after reset is accepted normally.

Verification
REQ-032 led_count=1, pix_data=24'h800001 -> the first bit is high for T1H, bits 22..1 high for T0H, and the last bit high for T1H; done occurs 2+24*TBIT+TLATCH cycles after start.
REQ-033 led_count=3, RAM={A5A5A5,00FF00,FFFFFF} -> addresses 0,1,2 are read once each, 72 contiguous TBIT periods with a decoded bitstream matching the RAM, then TLATCH low.
REQ-034 start with led_count=0 -> no pix_rd, line stays 0, done pulses the next cycle.
REQ-035 start re-asserted mid-frame and led_count changed mid-frame -> ignored, and the original frame completes unchanged.
REQ-036 reset asserted during pixel 1, bit 10 -> the line is 0 the next cycle, busy=0, no done; a new start with led_count=2 produces a correct full frame.
REQ-037 Bench run with T0H=2, T1H=4, TBIT=6, TLATCH=10 and led_count=255 -> addresses 0..254 are read in order with no wrap, and the total cycle count matches REQ-026.

Source files
------------

// File: rtl/ws2812_tx_sequencer.sv
// ---------------------------------------------------------------------------
// ws2812_tx_sequencer
//
// Streams a frame of GRB pixels from an external pixel RAM onto a WS2812 LED
// strip. Each pixel is 24 bits long and is sent MSB first (G7 first, B0 last).
// Each bit period is TBIT clocks long. The line is high for T1H clocks for a
// "1" bit and for T0H clocks for a "0" bit. After the last bit the line is held
// low for TLATCH clocks, which latches the strip. One cycle of done is then
// pulsed.
//
// While the current pixel is being shifted out, the next pixel is fetched
// into a holding register. This keeps the bit periods back to back across
// pixel boundaries.
//
// Ports
//   clk          system clock; every register uses its rising edge
//   reset        synchronous, active-high reset
//   start        one-cycle request to send a frame
//   led_count    number of LEDs in the frame; sampled when start is accepted
//   pix_rd       one-cycle read strobe to the pixel RAM
//   pix_addr     pixel index being read; meaningful while pix_rd=1 and 0 otherwise
//   pix_data     GRB word returned by the RAM one cycle after pix_rd
//   busy         high from start acceptance through the done cycle
//   done         one-cycle pulse when the frame and its latch time are finished
//   ws2812_dout  registered serial line to the strip
// ---------------------------------------------------------------------------
module ws2812_tx_sequencer #(
  parameter int T0H    = 11,
  parameter int T1H    = 22,
  parameter int TBIT   = 34,
  parameter int TLATCH = 1500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  led_count,
  output logic        pix_rd,
  output logic [7:0]  pix_addr,
  input  logic [23:0] pix_data,
  output logic        busy,
  output logic        done,
  output logic        ws2812_dout
);

  // The counters are sized from their terminal values. Because T1H < TBIT,
  // the high-time limits also fit in the phase counter width.
  localparam int PW = $clog2(TBIT + 1);
  localparam int LW = $clog2(TLATCH + 1);

  localparam logic [PW-1:0] PH_LAST = PW'(TBIT - 1);
  localparam logic [PW-1:0] PH_T0H  = PW'(T0H);
  localparam logic [PW-1:0] PH_T1H  = PW'(T1H);
  localparam logic [LW-1:0] LT_LAST = LW'(TLATCH - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    SEND,
    LATCH
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   phase_reg, phase_next;       // position inside the current bit
  logic [4:0]      bit_cnt_reg, bit_cnt_next;   // 23 down to 0 within a pixel
  logic [7:0]      index_reg, index_next;       // pixel currently on the line
  logic [7:0]      count_reg, count_next;       // frame length captured at start
  logic [23:0]     shift_reg, shift_next;       // bit [23] is the bit on the line
  logic [23:0]     hold_reg, hold_next;         // prefetched next pixel
  logic            hold_pend_reg, hold_pend_next;
  logic [LW-1:0]   latch_cnt_reg, latch_cnt_next;
  logic            dout_reg, dout_next;
  logic            zero_done_reg, zero_done_next;

  // Combinational helpers.
  logic            more_pixels;
  logic            bit_end;
  logic            prefetch;
  logic            latch_end;

  // Nine-bit compare, so the index+1 term cannot wrap when led_count=255.
  assign more_pixels = ({1'b0, index_reg} + 9'd1) < {1'b0, count_reg};
  assign bit_end     = (phase_reg == PH_LAST);
  assign latch_end   = (state_reg == LATCH) && (latch_cnt_reg == LT_LAST);

  // Next pixel is requested in the first cycle of bit 23 of the current pixel.
  // That cycle happens once per pixel, so the next pixel is read exactly once.
  assign prefetch = (state_reg == SEND) && (bit_cnt_reg == 5'd23) &&
                    (phase_reg == '0) && more_pixels;

  // pix_rd and pix_addr are decoded from state, so each read strobe lasts
  // exactly one cycle.
  always_comb begin
    pix_rd   = 1'b0;
    pix_addr = 8'd0;
    if (state_reg == FETCH) begin
      pix_rd   = 1'b1;
      pix_addr = index_reg;
    end else if (prefetch) begin
      pix_rd   = 1'b1;
      pix_addr = index_reg + 8'd1;
    end
  end

  assign busy        = (state_reg != IDLE);
  assign done        = latch_end | zero_done_reg;
  assign ws2812_dout = dout_reg;

  // Next-state and datapath logic.
  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    bit_cnt_next   = bit_cnt_reg;
    index_next     = index_reg;
    count_next     = count_reg;
    shift_next     = shift_reg;
    hold_next      = hold_reg;
    hold_pend_next = prefetch;
    latch_cnt_next = latch_cnt_reg;
    zero_done_next = 1'b0;
    dout_next      = 1'b0;

    // The RAM returns data one cycle after the prefetch strobe.
    if (hold_pend_reg) begin
      hold_next = pix_data;
    end

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (led_count != 8'd0) begin
            count_next = led_count;
            index_next = 8'd0;
            state_next = FETCH;
          end else begin
            // An empty frame finishes immediately and never raises busy.
            zero_done_next = 1'b1;
          end
        end
      end

      FETCH: begin
        state_next = WAIT_DATA;
      end

      WAIT_DATA: begin
        shift_next   = pix_data;
        bit_cnt_next = 5'd23;
        phase_next   = '0;
        state_next   = SEND;
      end

      SEND: begin
        if (bit_end) begin
          phase_next = '0;
          if (bit_cnt_reg == 5'd0) begin
            if (more_pixels) begin
              // The next pixel starts immediately after the last bit, with no gap.
              index_next   = index_reg + 8'd1;
              shift_next   = hold_reg;
              bit_cnt_next = 5'd23;
            end else begin
              latch_cnt_next = '0;
              state_next     = LATCH;
            end
          end else begin
            shift_next   = {shift_reg[22:0], 1'b0};
            bit_cnt_next = bit_cnt_reg - 5'd1;
          end
        end else begin
          phase_next = phase_reg + PW'(1);
        end
      end

      LATCH: begin
        if (latch_cnt_reg == LT_LAST) begin
          state_next = IDLE;
        end else begin
          latch_cnt_next = latch_cnt_reg + LW'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // dout_reg holds the value for the coming cycle. It is therefore computed
    // from the next phase and from the next bit on the line.
    if (state_next == SEND) begin
      dout_next = (phase_next < (shift_next[23] ? PH_T1H : PH_T0H));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      phase_reg     <= '0;
      bit_cnt_reg   <= 5'd0;
      index_reg     <= 8'd0;
      count_reg     <= 8'd0;
      shift_reg     <= 24'd0;
      hold_reg      <= 24'd0;
      hold_pend_reg <= 1'b0;
      latch_cnt_reg <= '0;
      dout_reg      <= 1'b0;
      zero_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      bit_cnt_reg   <= bit_cnt_next;
      index_reg     <= index_next;
      count_reg     <= count_next;
      shift_reg     <= shift_next;
      hold_reg      <= hold_next;
      hold_pend_reg <= hold_pend_next;
      latch_cnt_reg <= latch_cnt_next;
      dout_reg      <= dout_next;
      zero_done_reg <= zero_done_next;
    end
  end

endmodule

// File: tb/tb_ws2812_tx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ws2812_tx_sequencer
//
// Directed bench for ws2812_tx_sequencer. It uses short timing parameters, so
// a full 255-LED frame finishes in a reasonable number of cycles.
//
// A negedge monitor decodes the serial line into bits. From the line it also
// records rise times, bit-period gaps and high times. The monitor logs every
// pix_rd address and every done pulse.
//
// The main initial block drives the directed steps. It checks each result
// against expected values that it computes itself.
// ---------------------------------------------------------------------------
module tb_ws2812_tx_sequencer;

  localparam int T0H    = 2;
  localparam int T1H    = 4;
  localparam int TBIT   = 6;
  localparam int TLATCH = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  led_count;
  logic        pix_rd;
  logic [7:0]  pix_addr;
  logic [23:0] pix_data;
  logic        busy;
  logic        done;
  logic        ws2812_dout;

  ws2812_tx_sequencer #(
    .T0H   (T0H),
    .T1H   (T1H),
    .TBIT  (TBIT),
    .TLATCH(TLATCH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .led_count  (led_count),
    .pix_rd     (pix_rd),
    .pix_addr   (pix_addr),
    .pix_data   (pix_data),
    .busy       (busy),
    .done       (done),
    .ws2812_dout(ws2812_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // Pixel RAM model. Data is valid for exactly the one cycle after the read
  // strobe, and garbage is driven at all other times.
  logic [23:0] mem [0:255];
  always @(posedge clk) pix_data <= pix_rd ? mem[pix_addr] : 24'hC3C3C3;

  // Line monitor.
  int rd_q[$];
  bit bit_q[$];
  int rise_q[$];
  int done_cnt, done_cyc, bad_high, bad_gap, idle_high;
  int hi_len, lo_len, last_rise;
  bit prev_dout, in_frame;

  always @(negedge clk) begin
    if (pix_rd) rd_q.push_back(int'(pix_addr));
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (ws2812_dout && !busy) idle_high++;
    if (ws2812_dout) begin
      if (!prev_dout) begin
        if (in_frame && (cyc - last_rise) != TBIT) bad_gap++;
        in_frame  = 1'b1;
        last_rise = cyc;
        rise_q.push_back(cyc);
        hi_len = 0;
      end
      hi_len++;
      lo_len = 0;
    end else begin
      if (prev_dout) begin
        if (hi_len == T1H)      bit_q.push_back(1'b1);
        else if (hi_len == T0H) bit_q.push_back(1'b0);
        else                    bad_high++;
      end
      lo_len++;
      if (lo_len > TBIT) in_frame = 1'b0;
    end
    prev_dout = ws2812_dout;
  end

  int total, bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] n, output int s);
    @(posedge clk); #1;
    start     = 1'b1;
    led_count = n;
    s         = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Sends one frame of n pixels and checks it from start to finish. If
  // disturb is set, start is pulsed again mid-frame with a different
  // led_count. The frame must not change.
  task automatic run_frame(input string tag, input logic [7:0] n, input bit disturb);
    int s, rb, bb, qb, gb, hb, db, ib, budget, mism;
    logic exp_bit;
    rb = rd_q.size();
    bb = bit_q.size();
    qb = rise_q.size();
    gb = bad_gap;
    hb = bad_high;
    db = done_cnt;
    ib = idle_high;
    do_start(n, s);
    if (disturb) begin
      repeat (20) @(posedge clk);
      #1;
      check({tag, "_busy_mid"}, busy, 1);
      start     = 1'b1;
      led_count = 8'd5;
      @(posedge clk); #1;
      start = 1'b0;
    end
    budget = 2 + 24 * int'(n) * TBIT + TLATCH + 50;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != db) break;
      @(posedge clk); #1;
    end
    check({tag, "_done_seen"}, done_cnt - db, 1);
    check({tag, "_latency"}, done_cyc - s, 2 + 24 * int'(n) * TBIT + TLATCH);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_reads"}, rd_q.size() - rb, int'(n));
    mism = 0;
    for (int i = 0; i < int'(n); i++)
      if (rb + i >= rd_q.size() || rd_q[rb + i] != i) mism++;
    check({tag, "_addr_mism"}, mism, 0);
    check({tag, "_bits"}, bit_q.size() - bb, 24 * int'(n));
    mism = 0;
    for (int b = 0; b < 24 * int'(n); b++) begin
      exp_bit = mem[b / 24][23 - (b % 24)];
      if (bb + b >= bit_q.size() || bit_q[bb + b] !== exp_bit) mism++;
    end
    check({tag, "_bit_mism"}, mism, 0);
    check({tag, "_gap_err"}, bad_gap - gb, 0);
    check({tag, "_high_err"}, bad_high - hb, 0);
    check({tag, "_idle_high"}, idle_high - ib, 0);
    if (rise_q.size() > qb) check({tag, "_first_rise"}, rise_q[qb] - s, 3);
    else                    check({tag, "_first_rise"}, 0, 3);
    $display("frame %s: n=%0d start=%0d done=%0d", tag, n, s, done_cyc);
  endtask

  initial begin
    int s, rb, db, bb;
    logic [7:0] v;
    reset     = 1'b1;
    start     = 1'b0;
    led_count = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 24'd0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", ws2812_dout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pix_rd", pix_rd, 0);
    check("rst_pix_addr", pix_addr, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Empty frame: done on the next cycle, with no reads and no busy.
    rb = rd_q.size();
    do_start(8'd0, s);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_dout", ws2812_dout, 0);
    @(posedge clk); #1;
    check("zero_done_clear", done, 0);
    check("zero_reads", rd_q.size() - rb, 0);
    check("zero_done_cnt", done_cnt, 1);
    $display("frame zero: start=%0d", s);

    // Single pixel 800001: first and last bits are "1", the rest are "0".
    mem[0] = 24'h800001;
    run_frame("one", 8'd1, 1'b0);

    // Three pixels with mixed patterns.
    mem[0] = 24'hA5A5A5;
    mem[1] = 24'h00FF00;
    mem[2] = 24'hFFFFFF;
    run_frame("three", 8'd3, 1'b0);

    // A second start and a led_count change mid-frame must both be ignored.
    mem[0] = 24'h123456;
    mem[1] = 24'h89ABCD;
    run_frame("disturb", 8'd2, 1'b1);
    led_count = 8'd0;

    // Reset during pixel 1, bit 10 (bit 37 of the frame, phase 1).
    mem[2] = 24'h5A5A5A;
    db = done_cnt;
    bb = bit_q.size();
    do_start(8'd3, s);
    repeat (225) @(posedge clk);
    #1;
    check("abort_bits_before", bit_q.size() - bb, 37);
    check("abort_busy_before", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_dout", ws2812_dout, 0);
    check("abort_busy", busy, 0);
    check("abort_pix_rd", pix_rd, 0);
    check("abort_done", done, 0);
    repeat (24 * 3 * TBIT + TLATCH) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - db, 0);
    $display("frame abort: start=%0d reset_cycle=%0d", s, cyc - 1);
    run_frame("after_abort", 8'd2, 1'b0);

    // Longest frame: 255 LEDs, so addresses 0..254 with no wrap.
    for (int i = 0; i < 256; i++) begin
      v = i[7:0];
      mem[i] = {v, v ^ 8'hA5, ~v};
    end
    run_frame("full", 8'd255, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
